// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the TX block scheduler: FSM encoding,
// header magic and word-index width.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [15:0] HDR_MAGIC  = 16'hA55A;
    localparam int          WORD_IDX_W = 3;

    function automatic logic [31:0] hdrWord(input logic src);
        return {HDR_MAGIC, 15'd0, src};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with one-hot grant. Round-robin on ties by default;
// defining TX_SCHED_FIXED_PRIO_EN makes req[0] always win a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef TX_SCHED_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk, rst, advance};

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`else
    // rrPtr_q names the source that wins the next tie; it flips away from every granted source
    logic rrPtr_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = rrPtr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            rrPtr_q <= gnt[0];
        end
    end
`endif

endmodule

// File: rtl/tx_block_scheduler.sv
// Shares the 32-bit TX serializer between two 128-bit block sources, pacing words
// WORD_GAP_CYC cycles apart. Tie policy selected by TX_SCHED_FIXED_PRIO_EN (see rr_arb2).
module tx_block_scheduler
    import tx_sched_pkg::*;
#(
    parameter int WORD_GAP_CYC = 2048,
    parameter bit SEND_HDR     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    input  logic [127:0] req_data0,
    input  logic [127:0] req_data1,
    output logic [1:0]   req_ready,
    output logic         tx_start,
    output logic [31:0]  tx_data,
    output logic         busy,
    output logic         blk_done,
    output logic         blk_src
);

    localparam int GAP_W = $clog2(WORD_GAP_CYC);
    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(SEND_HDR ? 4 : 3);

    generate
        if (WORD_GAP_CYC < 4) begin : g_bad_gap
            $error("tx_block_scheduler: WORD_GAP_CYC must be at least 4");
        end
    endgenerate

    state_e                  state_q;
    logic [127:0]            block_q;
    logic                    src_q;
    logic [WORD_IDX_W-1:0]   wordIdx_q;
    logic [GAP_W-1:0]        gapCnt_q;
    logic [1:0]              reqReady_q;
    logic                    txStart_q;
    logic [31:0]             txData_q;
    logic                    busy_q;
    logic                    blkDone_q;
    logic [31:0]             word_d;
    logic [1:0]              gnt;
    logic                    advance;

    assign advance = (state_q == IDLE) && (req_valid != 2'b00);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (advance),
        .gnt     (gnt)
    );

    always_comb begin
        word_d = block_q[31:0];
        if (SEND_HDR) begin
            case (wordIdx_q)
                3'd0:    word_d = hdrWord(src_q);
                3'd1:    word_d = block_q[31:0];
                3'd2:    word_d = block_q[63:32];
                3'd3:    word_d = block_q[95:64];
                default: word_d = block_q[127:96];
            endcase
        end else begin
            case (wordIdx_q)
                3'd0:    word_d = block_q[31:0];
                3'd1:    word_d = block_q[63:32];
                3'd2:    word_d = block_q[95:64];
                default: word_d = block_q[127:96];
            endcase
        end
    end

    // Gap counter is loaded with GAP-2 so ISSUE plus the WAIT countdown spans exactly WORD_GAP_CYC cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            block_q    <= '0;
            src_q      <= 1'b0;
            wordIdx_q  <= '0;
            gapCnt_q   <= '0;
            reqReady_q <= 2'b00;
            txStart_q  <= 1'b0;
            txData_q   <= '0;
            busy_q     <= 1'b0;
            blkDone_q  <= 1'b0;
        end else begin
            reqReady_q <= 2'b00;
            txStart_q  <= 1'b0;
            blkDone_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (advance) begin
                        block_q    <= gnt[1] ? req_data1 : req_data0;
                        src_q      <= gnt[1];
                        wordIdx_q  <= '0;
                        reqReady_q <= gnt;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    txStart_q <= 1'b1;
                    txData_q  <= word_d;
                    gapCnt_q  <= GAP_W'(WORD_GAP_CYC - 2);
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (gapCnt_q == '0) begin
                        if (wordIdx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            wordIdx_q <= wordIdx_q + 1'b1;
                            state_q   <= ISSUE;
                        end
                    end else begin
                        gapCnt_q <= gapCnt_q - 1'b1;
                    end
                end
                DONE: begin
                    blkDone_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = reqReady_q;
    assign tx_start  = txStart_q;
    assign tx_data   = txData_q;
    assign busy      = busy_q;
    assign blk_done  = blkDone_q;
    assign blk_src   = src_q;

endmodule
